alu_result_buffer: RTL and testbench
====================================

// Module: alu_result_buffer
// PURPOSE
//  EX->WB result stage sitting directly downstream of the LC-3b ALU. Captures the ALU
//  output f together with its destination register and load strobes, and generates the
//  NZP condition bits for it. Buffers up to two results in a valid/ready skid buffer so
//  that writeback back-pressure never drops a result. Holds the architectural CC
//  register, which is updated as each result retires.
// PARAMETERS
//  WIDTH   16  datapath width; equals lc3b_word
//  DEST_W  3   destination register index width; equals lc3b_reg
// PORTS
//  clk              in   1      single clock; all state updates on rising edge
//  reset            in   1      synchronous, active-high
//  in_valid         in   1      upstream has a result this cycle
//  in_ready         out  1      buffer can accept a result this cycle
//  in_result        in   WIDTH  ALU output f
//  in_dest          in   DEST_W destination register
//  in_load_regfile  in   1      result is to be written to the register file
//  in_load_cc       in   1      result updates the CC register
//  flush            in   1      discard all buffered, not-yet-retired results
//  out_valid        out  1      head entry valid
//  out_ready        in   1      writeback accepts head entry
//  out_result       out  WIDTH  head result
//  out_dest         out  DEST_W head destination register
//  out_load_regfile out  1      head regfile write strobe; must be qualified with out_valid
//  out_nzp          out  3      head NZP bits {n,z,p}
//  cc_nzp           out  3      architectural CC register
// BEHAVIOUR
//  - Transfers: accept = in_valid & in_ready; retire = out_valid & out_ready.
//  - Storage: head register (H) and skid register (S); state EMPTY / ONE / FULL.
//  - in_ready = (state != FULL). Registered: no combinational path from out_ready.
//  - Out ports are driven straight from H. out_valid = (state != EMPTY).
//  - Latency: 1 cycle. A result accepted at edge k is on the out ports after edge k.
//  - Throughput: 1 result/cycle while out_ready is held high.
//  - NZP is computed at capture from in_result, using 16-bit two's complement:
//      n = in_result[WIDTH-1]; z = (in_result == 0); p = !n & !z.
//    Exactly one of the three bits is set.
//  - State transitions (no flush):
//      EMPTY: accept                -> ONE, H <= input
//      ONE:   accept & retire       -> ONE, H <= input
//             accept & !retire      -> FULL, S <= input
//             !accept & retire      -> EMPTY
//      FULL:  retire                -> ONE, H <= S
//             (in_ready = 0, so no accept is possible)
//      Any combination not listed leaves the state unchanged.
//  - Ordering: results leave strictly in the order they were accepted. No reordering.
//  - CC update: on each retire with out_load_cc = 1, cc_nzp <= out_nzp at that edge.
//    A retire with load_cc = 0 leaves cc_nzp unchanged.
//  - Flush: at the edge where flush = 1:
//      - the state goes to EMPTY;
//      - an input offered in the same cycle is dropped, even if in_ready = 1;
//      - a retire in the same cycle still completes, and still updates cc_nzp if
//        load_cc = 1;
//      - in_ready = 1 and out_valid = 0 from the next cycle.
//    Flush never modifies cc_nzp.
//  - Reset wins over flush and over every transfer.
//    After a reset edge: state = EMPTY, out_valid = 0, in_ready = 1, out_result = 0,
//    out_dest = 0, out_load_regfile = 0, out_nzp = 3'b000, cc_nzp = 3'b000.
//    A reset in the middle of a burst discards both entries.
//  - While out_valid = 1 and out_ready = 0, every out_* signal holds stable.
//  - Contents of an empty slot are don't-care and must never reach the out ports while
//    out_valid = 0.
// TESTING
//  1. Reset: assert reset for 2 cycles with in_valid = 1 ->
//     out_valid = 0, in_ready = 1, cc_nzp = 000.
//  2. Stream: out_ready = 1; send 0x0000, 0x8001, 0x7FFF (load_cc = 1) on consecutive
//     cycles -> out_nzp = 010, 100, 001 on consecutive cycles; cc_nzp ends at 001.
//  3. Back-pressure: out_ready = 0; send A = 0x0005, B = 0x0006 ->
//     in_ready = 0 after the 2nd accept and out_result holds 0x0005.
//     Then raise out_ready -> 0x0005, then 0x0006, and in_ready returns to 1.
//  4. CC gating: retire 0xFFFF with load_cc = 0 after a Z result with load_cc = 1 ->
//     cc_nzp stays 010.
//  5. Flush while FULL, with in_valid = 1 and out_ready = 1 on the same cycle ->
//     the head retires and its CC is applied; the skid entry and the offered input
//     are lost; next cycle out_valid = 0.
//  6. Reset while FULL -> both entries are discarded; the first post-reset input
//     appears after 1 cycle.

Source files
------------

// File: rtl/alu_result_buffer.sv
// EX->WB result stage for the LC-3b ALU: two-entry valid/ready skid buffer that tags
// each result with NZP bits at capture and retires into the architectural CC register.
module alu_result_buffer #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_load_regfile,
    input  logic              in_load_cc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_load_regfile,
    output logic [2:0]        out_nzp,
    output logic [2:0]        cc_nzp
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        H_HOLD      = 2'b00,
        H_LOAD_IN   = 2'b01,
        H_LOAD_SKID = 2'b10,
        H_CLEAR     = 2'b11
    } head_op_t;

    typedef struct packed {
        logic [WIDTH-1:0]  result;
        logic [DEST_W-1:0] dest;
        logic              load_regfile;
        logic              load_cc;
        logic [2:0]        nzp;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '0;

    function automatic logic [2:0] calc_nzp(input logic [WIDTH-1:0] value);
        logic n_s;
        logic z_s;
        n_s = value[WIDTH-1];
        z_s = (value == {WIDTH{1'b0}});
        return {n_s, z_s, ~n_s & ~z_s};
    endfunction

    state_t   state_r;
    state_t   next_state_s;
    head_op_t head_op_s;
    entry_t   head_r;
    entry_t   skid_r;
    entry_t   in_entry_s;
    logic [2:0] cc_nzp_r;
    logic     skid_load_s;
    logic     cc_load_s;
    logic     accept_s;
    logic     retire_s;

    assign in_entry_s = {in_result, in_dest, in_load_regfile, in_load_cc, calc_nzp(in_result)};

    // Handshake flags decode straight from the state register, so out_ready never reaches in_ready.
    assign in_ready  = (state_r != FULL);
    assign out_valid = (state_r != EMPTY);
    assign accept_s  = in_valid & in_ready;
    assign retire_s  = out_valid & out_ready;

    assign out_result       = head_r.result;
    assign out_dest         = head_r.dest;
    assign out_load_regfile = head_r.load_regfile;
    assign out_nzp          = head_r.nzp;
    assign cc_nzp           = cc_nzp_r;

    // Next-state and storage control; the head is cleared whenever it empties so stale data never shows.
    always_comb begin
        next_state_s = state_r;
        head_op_s    = H_HOLD;
        skid_load_s  = 1'b0;
        cc_load_s    = retire_s & head_r.load_cc;
        if (flush) begin
            next_state_s = EMPTY;
            head_op_s    = H_CLEAR;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        next_state_s = ONE;
                        head_op_s    = H_LOAD_IN;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (accept_s && retire_s) begin
                        head_op_s = H_LOAD_IN;
                    end else if (accept_s) begin
                        next_state_s = FULL;
                        skid_load_s  = 1'b1;
                    end else if (retire_s) begin
                        next_state_s = EMPTY;
                        head_op_s    = H_CLEAR;
                    end else begin
                        next_state_s = ONE;
                    end
                end
                FULL: begin
                    if (retire_s) begin
                        next_state_s = ONE;
                        head_op_s    = H_LOAD_SKID;
                    end else begin
                        next_state_s = FULL;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                    head_op_s    = H_CLEAR;
                end
            endcase
        end
    end

    // State, head/skid storage and CC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= EMPTY;
            head_r   <= ENTRY_ZERO;
            skid_r   <= ENTRY_ZERO;
            cc_nzp_r <= 3'b000;
        end else begin
            state_r <= next_state_s;
            case (head_op_s)
                H_LOAD_IN:   head_r <= in_entry_s;
                H_LOAD_SKID: head_r <= skid_r;
                H_CLEAR:     head_r <= ENTRY_ZERO;
                default:     head_r <= head_r;
            endcase
            if (skid_load_s) begin
                skid_r <= in_entry_s;
            end
            if (cc_load_s) begin
                cc_nzp_r <= head_r.nzp;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: directed scenarios followed by random traffic
// checked against a queue-based reference model of the buffer and CC register.
module tb_alu_result_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b1;
    logic        in_ready;
    logic [15:0] in_result = 16'h0000;
    logic [2:0]  in_dest = 3'd0;
    logic        in_load_regfile = 1'b0;
    logic        in_load_cc = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_dest;
    logic        out_load_regfile;
    logic [2:0]  out_nzp;
    logic [2:0]  cc_nzp;

    alu_result_buffer #(.WIDTH(16), .DEST_W(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_dest(in_dest),
        .in_load_regfile(in_load_regfile), .in_load_cc(in_load_cc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest),
        .out_load_regfile(out_load_regfile), .out_nzp(out_nzp),
        .cc_nzp(cc_nzp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [2:0]  d;
        logic        lr;
        logic        lc;
    } ent_t;

    ent_t       q[$];
    ent_t       pend_e;
    ent_t       popped;
    bit         pend_v = 1'b0;
    bit         known = 1'b0;
    bit         clean = 1'b0;
    logic [2:0] exp_cc = 3'b000;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [2:0] ref_nzp(input logic [15:0] v);
        if (v == 16'd0) return 3'b010;
        else if (v >= 16'h8000) return 3'b100;
        else return 3'b001;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare outputs to the model mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (known) begin
            chk("out_valid", {15'd0, out_valid}, {15'd0, q.size() != 0});
            chk("in_ready", {15'd0, in_ready}, {15'd0, q.size() < 2});
            chk("cc_nzp", {13'd0, cc_nzp}, {13'd0, exp_cc});
            if (q.size() != 0) begin
                chk("out_result", out_result, q[0].r);
                chk("out_dest", {13'd0, out_dest}, {13'd0, q[0].d});
                chk("out_load_regfile", {15'd0, out_load_regfile}, {15'd0, q[0].lr});
                chk("out_nzp", {13'd0, out_nzp}, {13'd0, ref_nzp(q[0].r)});
            end else if (clean) begin
                chk("reset_out_result", out_result, 16'h0000);
                chk("reset_out_dest", {13'd0, out_dest}, 16'h0000);
                chk("reset_out_load_regfile", {15'd0, out_load_regfile}, 16'h0000);
                chk("reset_out_nzp", {13'd0, out_nzp}, 16'h0000);
            end
        end
        if (reset) begin
            q.delete();
            exp_cc = 3'b000;
            clean  = 1'b1;
            known  = 1'b1;
        end else if (known) begin
            if (q.size() != 0 && out_ready) begin
                popped = q.pop_front();
                if (popped.lc) exp_cc = ref_nzp(popped.r);
            end
            if (flush) q.delete();
            if (pend_v) begin
                q.push_back(pend_e);
                clean = 1'b0;
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] r, input logic [2:0] d,
                        input logic lr, input logic lc, input logic fl,
                        input logic ordy, input logic rst);
        @(posedge clk);
        #2;
        in_valid        = v;
        in_result       = r;
        in_dest         = d;
        in_load_regfile = lr;
        in_load_cc      = lc;
        flush           = fl;
        out_ready       = ordy;
        reset           = rst;
        pend_v = v && !rst && !fl && known && (q.size() < 2);
        pend_e = '{r, d, lr, lc};
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        logic [15:0] rv;
        int pick;
        // Reset held for two cycles with a result offered.
        step(1'b1, 16'h1111, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h2222, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        // Streaming: Z, N, P back to back.
        step(1'b1, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h8001, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h7FFF, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);
        // Back-pressure fills both slots, then drains in order.
        step(1'b1, 16'h0005, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0006, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0007, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 3);
        // CC gating: Z with load_cc, then negative result without load_cc.
        step(1'b1, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'hFFFF, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 3);
        // Flush while full with an offered input and a retiring head.
        step(1'b1, 16'h1234, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h8888, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h4444, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 2);
        // Reset while full, then a fresh result.
        step(1'b1, 16'h00A1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00A2, 3'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h00A3, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h00AA, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);
        // Random traffic with corner operands, flushes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            pick = $urandom_range(0, 7);
            case (pick)
                0:       rv = 16'h0000;
                1:       rv = 16'h8000;
                2:       rv = 16'hFFFF;
                3:       rv = 16'h7FFF;
                default: rv = 16'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, rv, 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0);
        end
        idle(1'b1, 3);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
